// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: two-requester round-robin front end for a HyperBus core.
// A granted request is latched onto the core interface, issued as a one-cycle
// strobe, then waits for core completion or a TIMEOUT-cycle watchdog before
// acknowledging the granted requester.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mN_rrq / mN_wrq                  requester N read / write request (level)
//   mN_reg_space_i, mN_adr_i,
//   mN_dat_i, mN_mask_i              requester N transaction fields
//   mN_dat_o, mN_ack, mN_err         requester N read data, ack pulse, timeout flag
//   hbus_ready, hbus_valid, hbus_dat_i   core idle, core completion, core read data
//   hbus_rrq, hbus_wrq               core read / write strobes
//   hbus_reg_space_o, hbus_adr_o,
//   hbus_dat_o, hbus_mask_o          latched transaction fields to the core
//   busy                             high whenever the FSM is not idle
module hyperbus_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_rrq,
    input  logic        m0_wrq,
    input  logic        m0_reg_space_i,
    input  logic [31:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic        m0_mask_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic        m1_rrq,
    input  logic        m1_wrq,
    input  logic        m1_reg_space_i,
    input  logic [31:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic        m1_mask_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack,
    output logic        m1_err,

    input  logic        hbus_ready,
    input  logic        hbus_valid,
    input  logic [15:0] hbus_dat_i,
    output logic        hbus_rrq,
    output logic        hbus_wrq,
    output logic        hbus_reg_space_o,
    output logic [31:0] hbus_adr_o,
    output logic [15:0] hbus_dat_o,
    output logic        hbus_mask_o,
    output logic        busy
);

    // Counter is wide enough for the largest legal TIMEOUT.
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic             last_gnt;
    logic             gnt;
    logic             is_write;
    logic [CNT_W-1:0] cnt;

    logic        req0_c;
    logic        req1_c;
    logic        pick1_c;
    logic        sel_wrq_c;
    logic        sel_reg_c;
    logic [31:0] sel_adr_c;
    logic [15:0] sel_dat_c;
    logic        sel_mask_c;

    // Round-robin pick: requester 1 wins if alone, or on a tie when 0 was granted last.
    always_comb begin
        req0_c     = m0_rrq | m0_wrq;
        req1_c     = m1_rrq | m1_wrq;
        pick1_c    = req1_c & (~req0_c | ~last_gnt);
        sel_wrq_c  = pick1_c ? m1_wrq         : m0_wrq;
        sel_reg_c  = pick1_c ? m1_reg_space_i : m0_reg_space_i;
        sel_adr_c  = pick1_c ? m1_adr_i       : m0_adr_i;
        sel_dat_c  = pick1_c ? m1_dat_i       : m0_dat_i;
        sel_mask_c = pick1_c ? m1_mask_i      : m0_mask_i;
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_gnt         <= 1'b1;
            gnt              <= 1'b0;
            is_write         <= 1'b0;
            cnt              <= '0;
            busy             <= 1'b0;
            hbus_rrq         <= 1'b0;
            hbus_wrq         <= 1'b0;
            hbus_reg_space_o <= 1'b0;
            hbus_adr_o       <= '0;
            hbus_dat_o       <= '0;
            hbus_mask_o      <= 1'b0;
            m0_dat_o         <= '0;
            m0_ack           <= 1'b0;
            m0_err           <= 1'b0;
            m1_dat_o         <= '0;
            m1_ack           <= 1'b0;
            m1_err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hbus_ready && (req0_c || req1_c)) begin
                        gnt              <= pick1_c;
                        last_gnt         <= pick1_c;
                        // Write takes precedence when both request types are raised.
                        is_write         <= sel_wrq_c;
                        hbus_wrq         <= sel_wrq_c;
                        hbus_rrq         <= ~sel_wrq_c;
                        hbus_reg_space_o <= sel_reg_c;
                        hbus_adr_o       <= sel_adr_c;
                        hbus_dat_o       <= sel_dat_c;
                        hbus_mask_o      <= sel_mask_c;
                        busy             <= 1'b1;
                        state            <= ISSUE;
                    end
                end

                ISSUE: begin
                    hbus_rrq <= 1'b0;
                    hbus_wrq <= 1'b0;
                    cnt      <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    // Completion is checked first so it beats a coincident timeout.
                    if (hbus_valid) begin
                        if (!is_write) begin
                            if (gnt) begin
                                m1_dat_o <= hbus_dat_i;
                            end else begin
                                m0_dat_o <= hbus_dat_i;
                            end
                        end
                        m0_ack <= ~gnt;
                        m1_ack <= gnt;
                        m0_err <= 1'b0;
                        m1_err <= 1'b0;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        m0_ack <= ~gnt;
                        m1_ack <= gnt;
                        m0_err <= ~gnt;
                        m1_err <= gnt;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_err <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Self-checking bench for hyperbus_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_hyperbus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_rrq, m0_wrq, m0_reg_space_i, m0_mask_i;
    logic [31:0] m0_adr_i;
    logic [15:0] m0_dat_i, m0_dat_o;
    logic        m0_ack, m0_err;
    logic        m1_rrq, m1_wrq, m1_reg_space_i, m1_mask_i;
    logic [31:0] m1_adr_i;
    logic [15:0] m1_dat_i, m1_dat_o;
    logic        m1_ack, m1_err;
    logic        hbus_ready, hbus_valid;
    logic [15:0] hbus_dat_i;
    logic        hbus_rrq, hbus_wrq, hbus_reg_space_o, hbus_mask_o;
    logic [31:0] hbus_adr_o;
    logic [15:0] hbus_dat_o;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          last_model;
    logic [15:0] exp_dat [2];

    hyperbus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_rrq(m0_rrq), .m0_wrq(m0_wrq), .m0_reg_space_i(m0_reg_space_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_mask_i(m0_mask_i),
        .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_rrq(m1_rrq), .m1_wrq(m1_wrq), .m1_reg_space_i(m1_reg_space_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_mask_i(m1_mask_i),
        .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
        .hbus_ready(hbus_ready), .hbus_valid(hbus_valid), .hbus_dat_i(hbus_dat_i),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_reg_space_o(hbus_reg_space_o),
        .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_mask_o(hbus_mask_o),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic r, input logic w, input logic [31:0] a,
                           input logic [15:0] d, input logic mk, input logic rs);
        if (n == 0) begin
            m0_rrq = r; m0_wrq = w; m0_adr_i = a; m0_dat_i = d; m0_mask_i = mk; m0_reg_space_i = rs;
        end else begin
            m1_rrq = r; m1_wrq = w; m1_adr_i = a; m1_dat_i = d; m1_mask_i = mk; m1_reg_space_i = rs;
        end
    endtask

    task automatic drop_reqs();
        m0_rrq = 1'b0; m0_wrq = 1'b0; m1_rrq = 1'b0; m1_wrq = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop_reqs();
        hbus_valid = 1'b0;
        hbus_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_model = 1;
        exp_dat[0] = '0;
        exp_dat[1] = '0;
    endtask

    // Ticks until a core strobe is visible, bounded.
    task automatic wait_strobe(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hbus_rrq || hbus_wrq) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if ({hbus_rrq, hbus_wrq, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b want 000000",
                               {hbus_rrq, hbus_wrq, m0_ack, m1_ack, m0_err, m1_err});
        end
        n_checks++;
        if (hbus_adr_o !== 32'h0 || hbus_dat_o !== 16'h0 || m0_dat_o !== 16'h0 || m1_dat_o !== 16'h0) begin
            n_fail++; $display("FAIL reset_data adr=%h dat=%h d0=%h d1=%h want all 0",
                               hbus_adr_o, hbus_dat_o, m0_dat_o, m1_dat_o);
        end
    endtask

    task automatic test_basic_write();
        bit seen;
        int extra;
        set_req(0, 1'b0, 1'b1, 32'h100, 16'hBEEF, 1'b1, 1'b0);
        wait_strobe(seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL wr_strobe got none want hbus_wrq"); end
        n_checks++;
        if (hbus_wrq !== 1'b1 || hbus_rrq !== 1'b0 || hbus_adr_o !== 32'h100 ||
            hbus_dat_o !== 16'hBEEF || hbus_mask_o !== 1'b1) begin
            n_fail++; $display("FAIL wr_fields got w=%b r=%b adr=%h dat=%h mask=%b want 1 0 100 beef 1",
                               hbus_wrq, hbus_rrq, hbus_adr_o, hbus_dat_o, hbus_mask_o);
        end
        last_model = 0;
        extra = 0;
        repeat (3) begin
            tick();
            if (hbus_wrq || hbus_rrq) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL wr_single_pulse got %0d extra strobe cycles want 0", extra); end
        hbus_valid = 1'b1;
        tick();
        hbus_valid = 1'b0;
        n_checks++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m1_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack got ack0=%b err0=%b ack1=%b want 1 0 0", m0_ack, m0_err, m1_ack);
        end
        drop_reqs();
        tick();
        n_checks++;
        if (busy !== 1'b0 || m0_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_idle got busy=%b ack0=%b want 0 0", busy, m0_ack);
        end
    endtask

    task automatic test_round_robin();
        bit          seen;
        int          lat;
        logic [15:0] d;
        logic [31:0] exp_adr;
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'hA0, 16'h0, 1'b0, 1'b0);
        set_req(1, 1'b1, 1'b0, 32'hB0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_strobe(seen);
            exp_adr = (k % 2 == 0) ? 32'hA0 : 32'hB0;
            n_checks++;
            if (!seen || hbus_rrq !== 1'b1 || hbus_adr_o !== exp_adr) begin
                n_fail++; $display("FAIL rr_grant%0d got seen=%b rrq=%b adr=%h want 1 1 %h",
                                   k, seen, hbus_rrq, hbus_adr_o, exp_adr);
            end
            d = 16'($urandom);
            lat = int'($urandom_range(1, 4));
            repeat (lat) tick();
            hbus_dat_i = d;
            hbus_valid = 1'b1;
            tick();
            hbus_valid = 1'b0;
            exp_dat[k % 2] = d;
            n_checks++;
            if ({m1_ack, m0_ack} !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
                m0_dat_o !== exp_dat[0] || m1_dat_o !== exp_dat[1]) begin
                n_fail++; $display("FAIL rr_ack%0d got acks=%b d0=%h d1=%h want owner %0d d0=%h d1=%h",
                                   k, {m1_ack, m0_ack}, m0_dat_o, m1_dat_o, k % 2, exp_dat[0], exp_dat[1]);
            end
        end
        last_model = 1;
        drop_reqs();
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        set_req(1, 1'b1, 1'b0, 32'h55, 16'h0, 1'b0, 1'b1);
        wait_strobe(seen);
        n_checks++;
        if (!seen || hbus_reg_space_o !== 1'b1) begin
            n_fail++; $display("FAIL to_strobe got seen=%b reg=%b want 1 1", seen, hbus_reg_space_o);
        end
        last_model = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m1_ack && n < 50);
        n_checks++;
        if (n !== TO + 1) begin n_fail++; $display("FAIL to_latency got %0d cycles want %0d", n, TO + 1); end
        n_checks++;
        if (m1_err !== 1'b1 || m0_ack !== 1'b0 || m1_dat_o !== exp_dat[1]) begin
            n_fail++; $display("FAIL to_flags got err1=%b ack0=%b d1=%h want 1 0 %h",
                               m1_err, m0_ack, m1_dat_o, exp_dat[1]);
        end
        drop_reqs();
        tick();
        n_checks++;
        if (busy !== 1'b0 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin
            n_fail++; $display("FAIL to_idle got busy=%b ack1=%b err1=%b want 0 0 0", busy, m1_ack, m1_err);
        end
    endtask

    task automatic test_both_rw();
        bit seen;
        int rd_seen;
        int wr_cycles;
        set_req(0, 1'b1, 1'b1, 32'h77, 16'h1234, 1'b0, 1'b0);
        wait_strobe(seen);
        last_model = 0;
        rd_seen = (hbus_rrq === 1'b1) ? 1 : 0;
        wr_cycles = (hbus_wrq === 1'b1) ? 1 : 0;
        repeat (2) begin
            tick();
            if (hbus_rrq) rd_seen++;
            if (hbus_wrq) wr_cycles++;
        end
        hbus_dat_i = 16'hDEAD;
        hbus_valid = 1'b1;
        tick();
        hbus_valid = 1'b0;
        n_checks++;
        if (!seen || rd_seen !== 0 || wr_cycles !== 1) begin
            n_fail++; $display("FAIL rw_write_wins got seen=%b rrq_cycles=%0d wrq_cycles=%0d want 1 0 1",
                               seen, rd_seen, wr_cycles);
        end
        n_checks++;
        if (m0_ack !== 1'b1 || m0_dat_o !== exp_dat[0]) begin
            n_fail++; $display("FAIL rw_ack got ack0=%b d0=%h want 1 %h", m0_ack, m0_dat_o, exp_dat[0]);
        end
        drop_reqs();
        tick();
    endtask

    task automatic test_valid_at_timeout();
        bit seen;
        set_req(0, 1'b1, 1'b0, 32'h99, 16'h0, 1'b0, 1'b0);
        wait_strobe(seen);
        last_model = 0;
        repeat (TO) tick();
        hbus_dat_i = 16'hC0DE;
        hbus_valid = 1'b1;
        tick();
        hbus_valid = 1'b0;
        exp_dat[0] = 16'hC0DE;
        n_checks++;
        if (!seen || m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_dat_o !== 16'hC0DE) begin
            n_fail++; $display("FAIL tie_valid_wins got seen=%b ack0=%b err0=%b d0=%h want 1 1 0 c0de",
                               seen, m0_ack, m0_err, m0_dat_o);
        end
        drop_reqs();
        tick();
    endtask

    task automatic test_addr_hold();
        bit seen;
        int bad;
        set_req(0, 1'b1, 1'b0, 32'h10, 16'h0, 1'b0, 1'b0);
        wait_strobe(seen);
        last_model = 0;
        set_req(0, 1'b1, 1'b1, 32'h20, 16'hFFFF, 1'b1, 1'b1);
        bad = 0;
        repeat (4) begin
            tick();
            if (hbus_adr_o !== 32'h10 || hbus_dat_o !== 16'h0 || hbus_mask_o !== 1'b0) bad++;
        end
        hbus_dat_i = 16'h4242;
        hbus_valid = 1'b1;
        tick();
        hbus_valid = 1'b0;
        exp_dat[0] = 16'h4242;
        n_checks++;
        if (!seen || bad !== 0 || hbus_adr_o !== 32'h10) begin
            n_fail++; $display("FAIL hold_adr got seen=%b bad_cycles=%0d adr=%h want 1 0 10", seen, bad, hbus_adr_o);
        end
        n_checks++;
        if (m0_ack !== 1'b1 || m0_dat_o !== 16'h4242) begin
            n_fail++; $display("FAIL hold_ack got ack0=%b d0=%h want 1 4242", m0_ack, m0_dat_o);
        end
        drop_reqs();
        tick();
        n_checks++;
        if (hbus_adr_o !== 32'h10 || busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_idle got adr=%h busy=%b want 10 0", hbus_adr_o, busy);
        end
    endtask

    task automatic test_ignore();
        int strobes;
        int acks;
        strobes = 0;
        acks = 0;
        hbus_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h33, 16'h0, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            if (hbus_rrq || hbus_wrq || busy) strobes++;
        end
        drop_reqs();
        hbus_ready = 1'b1;
        hbus_valid = 1'b1;
        repeat (3) begin
            tick();
            if (hbus_rrq || hbus_wrq || busy) strobes++;
            if (m0_ack || m1_ack) acks++;
        end
        hbus_valid = 1'b0;
        n_checks++;
        if (strobes !== 0 || acks !== 0) begin
            n_fail++; $display("FAIL ignore got activity=%0d acks=%0d want 0 0", strobes, acks);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int acks;
        set_req(1, 1'b1, 1'b0, 32'hABC, 16'h0, 1'b0, 1'b0);
        wait_strobe(seen);
        tick();
        rst = 1'b1;
        drop_reqs();
        tick();
        rst = 1'b0;
        last_model = 1;
        exp_dat[0] = '0;
        exp_dat[1] = '0;
        n_checks++;
        if (!seen || busy !== 1'b0 || hbus_adr_o !== 32'h0 || m1_dat_o !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid got seen=%b busy=%b adr=%h d1=%h want 1 0 0 0",
                               seen, busy, hbus_adr_o, m1_dat_o);
        end
        acks = 0;
        hbus_valid = 1'b1;
        hbus_dat_i = 16'h1111;
        repeat (4) begin
            tick();
            hbus_valid = 1'b0;
            if (m0_ack || m1_ack) acks++;
        end
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("FAIL rst_no_ack got %0d acks want 0", acks); end
        set_req(0, 1'b0, 1'b1, 32'h200, 16'h5A5A, 1'b0, 1'b0);
        wait_strobe(seen);
        last_model = 0;
        repeat (2) tick();
        hbus_valid = 1'b1;
        tick();
        hbus_valid = 1'b0;
        n_checks++;
        if (!seen || m0_ack !== 1'b1 || m0_err !== 1'b0 || hbus_adr_o !== 32'h200) begin
            n_fail++; $display("FAIL rst_next got seen=%b ack0=%b err0=%b adr=%h want 1 1 0 200",
                               seen, m0_ack, m0_err, hbus_adr_o);
        end
        drop_reqs();
        tick();
    endtask

    // Random mix of requesters, types, fields and completion latency, scored
    // against a transaction-level model of arbitration and completion timing.
    task automatic test_random();
        bit          seen;
        int          t [2];
        int          w, lat, n, exp_n;
        bit          wr, noise, timed_out;
        logic [31:0] a [2];
        logic [15:0] d [2];
        logic        mk [2];
        logic        rs [2];
        logic [15:0] rdata;
        int          bad;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                t[r]  = int'($urandom_range(0, 3));
                a[r]  = $urandom;
                d[r]  = 16'($urandom);
                mk[r] = 1'($urandom);
                rs[r] = 1'($urandom);
            end
            if (t[0] == 0 && t[1] == 0) t[$urandom_range(0, 1)] = 1;
            for (int r = 0; r < 2; r++) begin
                set_req(r, (t[r] == 1 || t[r] == 3), (t[r] >= 2), a[r], d[r], mk[r], rs[r]);
            end
            if (t[0] != 0 && t[1] != 0) w = (last_model == 0) ? 1 : 0;
            else w = (t[1] != 0) ? 1 : 0;
            wr = (t[w] >= 2);
            lat = int'($urandom_range(1, TO + 2));
            timed_out = (lat > TO);
            exp_n = timed_out ? TO + 1 : lat + 1;
            rdata = 16'($urandom);
            noise = 1'($urandom);

            wait_strobe(seen);
            n_checks++;
            if (!seen || hbus_wrq !== wr || hbus_rrq !== !wr || hbus_adr_o !== a[w] ||
                hbus_dat_o !== d[w] || hbus_mask_o !== mk[w] || hbus_reg_space_o !== rs[w]) begin
                n_fail++; $display("FAIL rnd%0d_issue got seen=%b w=%b r=%b adr=%h dat=%h mk=%b rs=%b want w=%b adr=%h dat=%h mk=%b rs=%b",
                                   it, seen, hbus_wrq, hbus_rrq, hbus_adr_o, hbus_dat_o, hbus_mask_o,
                                   hbus_reg_space_o, wr, a[w], d[w], mk[w], rs[w]);
            end
            last_model = w;

            n = 0;
            bad = 0;
            hbus_dat_i = rdata;
            while (n < 40) begin
                hbus_valid = (!timed_out && n == lat) || (n == 0 && noise);
                if (n == 1) begin
                    m0_adr_i = $urandom;
                    m1_adr_i = $urandom;
                end
                tick();
                n++;
                hbus_valid = 1'b0;
                if (hbus_rrq || hbus_wrq || hbus_adr_o !== a[w]) bad++;
                if (m0_ack || m1_ack) break;
            end
            if (!wr && !timed_out) exp_dat[w] = rdata;
            n_checks++;
            if (n !== exp_n || bad !== 0) begin
                n_fail++; $display("FAIL rnd%0d_latency got %0d cycles bad=%0d want %0d cycles bad=0",
                                   it, n, bad, exp_n);
            end
            n_checks++;
            if ({m1_ack, m0_ack} !== ((w == 1) ? 2'b10 : 2'b01) ||
                (w == 1 ? m1_err : m0_err) !== timed_out ||
                m0_dat_o !== exp_dat[0] || m1_dat_o !== exp_dat[1]) begin
                n_fail++; $display("FAIL rnd%0d_ack got acks=%b errs=%b d0=%h d1=%h want owner %0d err=%b d0=%h d1=%h",
                                   it, {m1_ack, m0_ack}, {m1_err, m0_err}, m0_dat_o, m1_dat_o,
                                   w, timed_out, exp_dat[0], exp_dat[1]);
            end
            drop_reqs();
            tick();
            n_checks++;
            if (busy !== 1'b0 || hbus_adr_o !== a[w] || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_idle got busy=%b adr=%h acks=%b want 0 %h 00",
                                   it, busy, hbus_adr_o, {m1_ack, m0_ack}, a[w]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        hbus_ready = 1'b1;
        hbus_valid = 1'b0;
        hbus_dat_i = '0;
        set_req(0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        last_model = 1;
        exp_dat[0] = '0;
        exp_dat[1] = '0;

        test_reset();
        test_basic_write();
        test_round_robin();
        test_timeout();
        test_both_rw();
        test_valid_at_timeout();
        test_addr_hold();
        test_ignore();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_arbiter.md
HYPERBUS_ARBITER -- requirements
Module: hyperbus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 1024, WAIT-state cycles before a transaction is abandoned; legal range 2..65535.
REQ-002 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- mN_rrq  in  1  requester N (N=0,1) read request, level, held until mN_ack.
- mN_wrq  in  1  requester N write request, level, held until mN_ack.
- mN_reg_space_i  in  1  requester N register-space select.
- mN_adr_i  in  32  requester N word address.
- mN_dat_i  in  16  requester N write data.
- mN_mask_i  in  1  requester N write mask.
- mN_dat_o  out  16  requester N read data, valid when mN_ack=1.
- mN_ack  out  1  requester N completion pulse, one cycle.
- mN_err  out  1  requester N timeout flag, qualified by mN_ack.
- hbus_ready  in  1  core idle, can accept a request.
- hbus_valid  in  1  core completion pulse; read data present on hbus_dat_i.
- hbus_dat_i  in  16  core read data.
- hbus_rrq  out  1  core read strobe.
- hbus_wrq  out  1  core write strobe.
- hbus_reg_space_o  out  1  core register-space select.
- hbus_adr_o  out  32  core address.
- hbus_dat_o  out  16  core write data.
- hbus_mask_o  out  1  core write mask.
- busy  out  1  high in any state other than IDLE.
REQ-003 clk is the only clock; rst is synchronous and active-high; there is no other reset input.

Function
REQ-004 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs are registered.
REQ-005 IDLE: if hbus_ready=1 and any mN_rrq/mN_wrq=1, the block grants one requester and moves to ISSUE on the next edge; otherwise it stays in IDLE.
REQ-006 Arbitration: round-robin via a last-grant pointer.
- Both requesting: the requester not granted last wins.
- One requesting: that requester wins.
- The pointer updates on each grant.
REQ-007 If mN_wrq and mN_rrq are both high for the granted requester, the write is performed.
REQ-008 On grant, mN_adr_i, mN_dat_i, mN_mask_i, mN_reg_space_i and the read/write type are latched into the hbus_* outputs; later changes on requester inputs are ignored until DONE.
REQ-009 ISSUE lasts exactly one cycle.
- hbus_wrq or hbus_rrq (never both) is high for that cycle only.
- Next state is WAIT.
REQ-010 WAIT exit on completion: on the cycle hbus_valid=1, a read latches hbus_dat_i into mN_dat_o of the granted requester; next state is DONE with err=0.
REQ-011 WAIT exit on timeout: the cycle counter starts at 0 on WAIT entry and increments each WAIT cycle; when it reaches TIMEOUT-1 without hbus_valid, next state is DONE with err=1 and mN_dat_o is unchanged.
REQ-012 hbus_valid and timeout on the same cycle: completion wins and err=0.
REQ-013 DONE lasts one cycle.
- mN_ack=1 for the granted requester only; mN_err as decided in WAIT.
- No arbitration in DONE, so a request held through ack is not re-granted.
- Next state is IDLE.
REQ-014 Minimum transaction time is 4 cycles: grant edge, ISSUE, one or more WAIT cycles, DONE. Back-to-back grants resume from IDLE the cycle after DONE.
REQ-015 hbus_valid outside WAIT is ignored; requests deasserted before grant cause no transaction.
REQ-016 hbus_adr_o, hbus_dat_o, hbus_mask_o and hbus_reg_space_o hold their last latched values when not in ISSUE or WAIT.

Reset
REQ-017 Reset values: state=IDLE, last-grant pointer=1 (requester 0 wins the first tie), counter=0.
REQ-018 All outputs reset to 0, including hbus_rrq, hbus_wrq, mN_ack, mN_err, busy, mN_dat_o, hbus_adr_o and hbus_dat_o.
REQ-019 Reset asserted mid-transaction aborts it: no ack is issued, and the FSM is in IDLE on the edge after rst is sampled high.

Verification
REQ-020 m0_wrq=1, adr=0x100, dat=0xBEEF, hbus_ready=1, hbus_valid 3 cycles after ISSUE -> one hbus_wrq pulse with adr 0x100/dat 0xBEEF; m0_ack=1 one cycle later with m0_err=0.
REQ-021 m0_rrq and m1_rrq asserted together and held through 4 transactions -> grants alternate 0,1,0,1; each ack carries the hbus_dat_i captured for that grant.
REQ-022 m1_rrq with hbus_valid never asserted, TIMEOUT=8 -> m1_ack=1 and m1_err=1 exactly 8 WAIT cycles after ISSUE; FSM returns to IDLE.
REQ-023 m0_rrq=1 and m0_wrq=1 together -> a single hbus_wrq pulse and no hbus_rrq.
REQ-024 rst pulsed during WAIT, then hbus_valid arrives -> no mN_ack; busy=0 after reset; the next request is served normally.
REQ-025 m0 changes adr_i from 0x10 to 0x20 during WAIT -> hbus_adr_o stays 0x10 until DONE.
